// File: rtl/bit_align_ctrl.sv
// Per-lane bitslip controller: slips each deserializer lane until its error count
// stays below threshold for LOCK_WINDOWS consecutive observation windows.
module bit_align_ctrl #(
  parameter int NUM_CH        = 3,
  parameter int WINDOW_LEN    = 256,
  parameter int ERR_THRESH    = 32,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_WINDOWS  = 4,
  parameter int SLIP_MAX      = 10
) (
  input  logic                clk_1x_in,
  input  logic                reset_n_in,
  input  logic                enable_in,
  input  logic [NUM_CH-1:0]   error_in,
  output logic [NUM_CH-1:0]   slip_bit,
  output logic [NUM_CH-1:0]   sync_done,
  output logic                all_synced,
  output logic [4*NUM_CH-1:0] slip_count,
  output logic [NUM_CH-1:0]   align_err
);

  // state     | meaning
  // SEARCH    | counting errors per window, waiting for LOCK_WINDOWS good windows
  // SLIP      | one-cycle bitslip request to the deserializer
  // SETTLE    | error_in ignored while the deserializer realigns
  // LOCKED    | aligned; still watching for an error burst
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SLIP   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam int WW = $clog2(WINDOW_LEN);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW_LEN - 1);
  localparam logic [EW-1:0] ERR_LAST    = EW'(ERR_THRESH - 1);
  localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_WINDOWS - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    SLIP_LAST   = 4'(SLIP_MAX - 1);

  logic all_synced_q;

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      logic [1:0]    state_q, state_d;
      logic [WW-1:0] win_q, win_d;
      logic [EW-1:0] err_q, err_d;
      logic [GW-1:0] good_q, good_d;
      logic [SW-1:0] settle_q, settle_d;
      logic [3:0]    slip_cnt_q, slip_cnt_d;
      logic          slip_q, slip_d;
      logic          sync_q, sync_d;
      logic          aerr_q, aerr_d;
      logic          locked_q, locked_d;
      logic          err_hit, win_end, slip_wrap;

      assign err_hit   = error_in[k] && (err_q == ERR_LAST);
      assign win_end   = (win_q == WIN_LAST);
      assign slip_wrap = (slip_cnt_q == SLIP_LAST);

      always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        err_d      = err_q;
        good_d     = good_q;
        settle_d   = settle_q;
        slip_cnt_d = slip_cnt_q;
        slip_d     = 1'b0;
        sync_d     = sync_q;
        aerr_d     = aerr_q;
        locked_d   = locked_q;

        if (!enable_in) begin
          state_d  = ST_SEARCH;
          win_d    = '0;
          err_d    = '0;
          good_d   = '0;
          settle_d = '0;
          sync_d   = 1'b0;
        end else begin
          case (state_q)
            ST_SEARCH, ST_LOCKED: begin
              // threshold hit wins over a coincident window end
              if (err_hit) begin
                state_d    = ST_SLIP;
                slip_d     = 1'b1;
                sync_d     = 1'b0;
                win_d      = '0;
                err_d      = '0;
                good_d     = '0;
                slip_cnt_d = slip_wrap ? 4'd0 : slip_cnt_q + 4'd1;
                if (slip_wrap) begin
                  if (!locked_q) aerr_d = 1'b1;
                  locked_d = 1'b0;
                end
              end else if (win_end) begin
                win_d = '0;
                err_d = '0;
                if (state_q == ST_SEARCH) begin
                  if (good_q == GOOD_LAST) begin
                    state_d  = ST_LOCKED;
                    good_d   = '0;
                    sync_d   = 1'b1;
                    aerr_d   = 1'b0;
                    locked_d = 1'b1;
                  end else begin
                    good_d = good_q + GW'(1);
                  end
                end
              end else begin
                win_d = win_q + WW'(1);
                if (error_in[k]) err_d = err_q + EW'(1);
              end
            end
            ST_SLIP: begin
              state_d  = ST_SETTLE;
              settle_d = SETTLE_LOAD;
            end
            ST_SETTLE: begin
              if (settle_q == '0) begin
                state_d = ST_SEARCH;
                win_d   = '0;
                err_d   = '0;
              end else begin
                settle_d = settle_q - SW'(1);
              end
            end
            default: state_d = ST_SEARCH;
          endcase
        end
      end

      always_ff @(posedge clk_1x_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
          state_q    <= ST_SEARCH;
          win_q      <= '0;
          err_q      <= '0;
          good_q     <= '0;
          settle_q   <= '0;
          slip_cnt_q <= '0;
          slip_q     <= 1'b0;
          sync_q     <= 1'b0;
          aerr_q     <= 1'b0;
          locked_q   <= 1'b0;
        end else begin
          state_q    <= state_d;
          win_q      <= win_d;
          err_q      <= err_d;
          good_q     <= good_d;
          settle_q   <= settle_d;
          slip_cnt_q <= slip_cnt_d;
          slip_q     <= slip_d;
          sync_q     <= sync_d;
          aerr_q     <= aerr_d;
          locked_q   <= locked_d;
        end
      end

      assign slip_bit[k]         = slip_q;
      assign sync_done[k]        = sync_q;
      assign align_err[k]        = aerr_q;
      assign slip_count[4*k +: 4] = slip_cnt_q;
    end
  endgenerate

  always_ff @(posedge clk_1x_in or negedge reset_n_in) begin
    if (!reset_n_in) all_synced_q <= 1'b0;
    else             all_synced_q <= &sync_done;
  end

  assign all_synced = all_synced_q;

endmodule

// File: tb/tb_bit_align_ctrl.sv
// Directed bench for bit_align_ctrl with short windows; expected edges are hand-computed.
module tb_bit_align_ctrl;
  localparam int NUM_CH        = 3;
  localparam int WINDOW_LEN    = 16;
  localparam int ERR_THRESH    = 4;
  localparam int SETTLE_CYCLES = 4;
  localparam int LOCK_WINDOWS  = 2;
  localparam int SLIP_MAX      = 10;

  logic                clk_1x_in = 1'b0;
  logic                reset_n_in;
  logic                enable_in;
  logic [NUM_CH-1:0]   error_in;
  logic [NUM_CH-1:0]   slip_bit;
  logic [NUM_CH-1:0]   sync_done;
  logic                all_synced;
  logic [4*NUM_CH-1:0] slip_count;
  logic [NUM_CH-1:0]   align_err;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  always #5 clk_1x_in = ~clk_1x_in;

  bit_align_ctrl #(
    .NUM_CH(NUM_CH), .WINDOW_LEN(WINDOW_LEN), .ERR_THRESH(ERR_THRESH),
    .SETTLE_CYCLES(SETTLE_CYCLES), .LOCK_WINDOWS(LOCK_WINDOWS), .SLIP_MAX(SLIP_MAX)
  ) dut (
    .clk_1x_in(clk_1x_in), .reset_n_in(reset_n_in), .enable_in(enable_in),
    .error_in(error_in), .slip_bit(slip_bit), .sync_done(sync_done),
    .all_synced(all_synced), .slip_count(slip_count), .align_err(align_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_1x_in);
    #1;
    edge_n++;
  endtask

  // After this returns, the next rising edge is edge 1 of the scenario.
  task automatic do_reset();
    enable_in  = 1'b0;
    error_in   = '0;
    reset_n_in = 1'b0;
    step();
    step();
    reset_n_in = 1'b1;
    step();
    enable_in = 1'b1;
    edge_n    = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] slip_seen;
    logic       pulse;
    int         npulse;

    reset_n_in = 1'b0;
    enable_in  = 1'b0;
    error_in   = '0;
    step();
    check_val("rst_sync",   32'(sync_done),  32'd0);
    check_val("rst_slip",   32'(slip_bit),   32'd0);
    check_val("rst_all",    32'(all_synced), 32'd0);
    check_val("rst_cnt",    32'(slip_count), 32'd0);
    check_val("rst_aerr",   32'(align_err),  32'd0);

    // clean lanes lock after two windows
    do_reset();
    slip_seen = '0;
    for (int e = 1; e <= 34; e++) begin
      step();
      slip_seen = slip_seen | slip_bit;
      if (e == 31) check_val("s1_sync31", 32'(sync_done), 32'd0);
      if (e == 32) begin
        check_val("s1_sync32", 32'(sync_done), 32'd7);
        check_val("s1_all32",  32'(all_synced), 32'd0);
      end
      if (e == 33) check_val("s1_all33", 32'(all_synced), 32'd1);
    end
    check_val("s1_noslip", 32'(slip_seen),  32'd0);
    check_val("s1_cnt",    32'(slip_count), 32'd0);

    // lane 1 stuck in error: slips every 9 cycles, align_err on wrap
    do_reset();
    error_in = 3'b010;
    npulse   = 0;
    for (int e = 1; e <= 94; e++) begin
      step();
      pulse = (e >= 4) && (((e - 4) % 9) == 0);
      check_val("s2_slip", 32'(slip_bit), pulse ? 32'h2 : 32'h0);
      if (pulse) begin
        npulse++;
        check_val("s2_cnt", 32'(slip_count[7:4]), 32'(npulse % 10));
      end
      if (e == 31) check_val("s2_sync31", 32'(sync_done), 32'd0);
      if (e == 32) check_val("s2_sync32", 32'(sync_done), 32'h5);
      if (e == 84) check_val("s2_aerr84", 32'(align_err), 32'd0);
      if (e == 85) check_val("s2_aerr85", 32'(align_err), 32'h2);
    end
    check_val("s2_all", 32'(all_synced), 32'd0);
    enable_in = 1'b0;
    step();
    check_val("s2_dis_sync", 32'(sync_done),  32'd0);
    check_val("s2_dis_slip", 32'(slip_bit),   32'd0);
    check_val("s2_dis_cnt",  32'(slip_count), 32'h010);
    check_val("s2_dis_aerr", 32'(align_err),  32'h2);
    enable_in = 1'b1;
    for (int e = 96; e <= 127; e++) begin
      step();
      if (e == 99) begin
        check_val("s2_re_slip", 32'(slip_bit),   32'h2);
        check_val("s2_re_cnt",  32'(slip_count), 32'h020);
      end
      if (e == 126) check_val("s2_re_sync126", 32'(sync_done), 32'd0);
      if (e == 127) check_val("s2_re_sync127", 32'(sync_done), 32'h5);
    end

    // lane 0: 3 errors per window never slips; lane 2: 4th error on window's last cycle
    do_reset();
    slip_seen = '0;
    for (int e = 1; e <= 56; e++) begin
      error_in[0] = (((e - 1) % 16) == 2) || (((e - 1) % 16) == 7) || (((e - 1) % 16) == 11);
      error_in[1] = 1'b0;
      error_in[2] = (e >= 13) && (e <= 16);
      step();
      slip_seen = slip_seen | slip_bit;
      if (e == 16) check_val("s3_coincide", 32'(slip_bit), 32'h4);
      if (e == 31) check_val("s3_sync31", 32'(sync_done), 32'd0);
      if (e == 32) check_val("s3_sync32", 32'(sync_done), 32'h3);
      if (e == 52) check_val("s3_sync52", 32'(sync_done), 32'h3);
      if (e == 53) check_val("s3_sync53", 32'(sync_done), 32'h7);
    end
    check_val("s3_noslip0", 32'(slip_seen[0]), 32'd0);
    check_val("s3_cnt",     32'(slip_count),   32'h100);

    // error burst on locked lane 2, then relock
    do_reset();
    for (int e = 1; e <= 82; e++) begin
      error_in = ((e >= 41) && (e <= 44)) ? 3'b100 : 3'b000;
      step();
      if (e == 40) check_val("s4_all40", 32'(all_synced), 32'd1);
      if (e == 44) begin
        check_val("s4_sync44", 32'(sync_done),  32'h3);
        check_val("s4_slip44", 32'(slip_bit),   32'h4);
        check_val("s4_all44",  32'(all_synced), 32'd1);
      end
      if (e == 45) check_val("s4_all45",  32'(all_synced), 32'd0);
      if (e == 80) check_val("s4_sync80", 32'(sync_done),  32'h3);
      if (e == 81) check_val("s4_sync81", 32'(sync_done),  32'h7);
      if (e == 82) check_val("s4_all82",  32'(all_synced), 32'd1);
    end

    // asynchronous reset while lane 1 is settling
    do_reset();
    for (int e = 1; e <= 46; e++) begin
      error_in = ((e >= 41) && (e <= 44)) ? 3'b010 : 3'b000;
      step();
    end
    check_val("s5_pre_cnt",  32'(slip_count), 32'h010);
    check_val("s5_pre_sync", 32'(sync_done),  32'h5);
    reset_n_in = 1'b0;
    #1;
    check_val("s5_rst_sync", 32'(sync_done),  32'd0);
    check_val("s5_rst_cnt",  32'(slip_count), 32'd0);
    check_val("s5_rst_slip", 32'(slip_bit),   32'd0);
    check_val("s5_rst_all",  32'(all_synced), 32'd0);
    check_val("s5_rst_aerr", 32'(align_err),  32'd0);
    reset_n_in = 1'b1;
    error_in   = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/bit_align_ctrl.md
BIT_ALIGN_CTRL -- requirements
Module: bit_align_ctrl

Interface
REQ-001 Parameter NUM_CH, 3: number of independent serial channels.
REQ-002 Parameter WINDOW_LEN, 256: cycles per error-observation window (>=4).
REQ-003 Parameter ERR_THRESH, 32: errors per window that trigger a slip (1..WINDOW_LEN).
REQ-004 Parameter SETTLE_CYCLES, 16: cycles error_in is ignored after a slip (>=1).
REQ-005 Parameter LOCK_WINDOWS, 4: consecutive good windows required for lock (>=1).
REQ-006 Parameter SLIP_MAX, 10: bit positions per word; slip counter modulus (2..15).
REQ-007 clk_1x_in  input  1  pixel-rate clock; the only clock.
REQ-008 reset_n_in  input  1  asynchronous, active-low reset.
REQ-009 enable_in  input  1  synchronous enable; low holds all channels cleared.
REQ-010 error_in  input  NUM_CH  per-channel decode/alignment error flag, sampled each cycle.
REQ-011 slip_bit  output  NUM_CH  per-channel one-cycle bitslip request to the deserializer.
REQ-012 sync_done  output  NUM_CH  per-channel lock level.
REQ-013 all_synced  output  1  registered AND of all sync_done bits.
REQ-014 slip_count  output  4*NUM_CH  per-channel slip position; channel k occupies bits [4k+3:4k].
REQ-015 align_err  output  NUM_CH  per-channel sticky flag: full slip cycle completed without lock.

Function
REQ-016 Each channel shall run an identical, independent FSM: SEARCH, SLIP, SETTLE, LOCKED.
REQ-017 SEARCH/LOCKED: window counter counts 0..WINDOW_LEN-1; error counter increments on each sampled error_in=1 and never exceeds ERR_THRESH.
REQ-018 On the edge sampling the ERR_THRESH-th error of a window, the FSM shall go to SLIP, clear window/error/good-window counters; sync_done is cleared on the same edge if set.
REQ-019 slip_bit shall be registered, high exactly the single cycle the FSM is in SLIP.
REQ-020 SLIP shall last one cycle, then SETTLE for exactly SETTLE_CYCLES cycles with error_in ignored, then SEARCH with a fresh window.
REQ-021 A window ending (window counter = WINDOW_LEN-1) below threshold is good: good-window counter increments; window and error counters restart next cycle.
REQ-022 When the good-window counter reaches LOCK_WINDOWS in SEARCH, the FSM shall enter LOCKED and sync_done shall be 1 from the following cycle.
REQ-023 If the threshold-reaching error and the window's last cycle coincide, the slip shall take priority.
REQ-024 slip_count shall increment on entry to SLIP, wrapping SLIP_MAX-1 -> 0; it is not cleared on lock.
REQ-025 align_err shall set on the wrap of slip_count when the channel has not locked since its previous wrap (or since reset); cleared only on entry to LOCKED or reset.
REQ-026 enable_in=0 shall, on the next edge, force SEARCH, clear all counters except slip_count, and drive slip_bit and sync_done to 0; align_err holds.
REQ-027 all_synced shall be 1 one cycle after all sync_done bits are 1, and 0 one cycle after any drops.

Reset
REQ-028 reset_n_in=0 shall immediately force all FSMs to SEARCH and all counters, slip_bit, sync_done, all_synced, slip_count, and align_err to 0, including mid-SLIP or mid-SETTLE.
REQ-029 After reset_n_in rises, the first window shall begin on the first edge with enable_in=1.

Verification (NUM_CH=3, WINDOW_LEN=16, ERR_THRESH=4, SETTLE_CYCLES=4, LOCK_WINDOWS=2, SLIP_MAX=10)
REQ-030 error_in=0, enable_in=1 from edge 1 -> sync_done=3'b111 after edge 32, not after edge 31; all_synced=1 after edge 33; slip_bit never high.
REQ-031 error_in[1] held 1 -> slip_bit[1] pulses every 9 cycles, first high after edge 4; slip_count[7:4] steps 1..9,0; align_err[1]=1 on the tenth pulse; channels 0 and 2 lock normally.
REQ-032 Exactly 3 errors in every window on channel 0 -> no slip; sync_done[0]=1 after edge 32.
REQ-033 All locked, then error_in[2]=1 for 4 consecutive cycles -> sync_done[2]=0 and slip_bit[2]=1 in the same cycle; all_synced=0 one cycle later; relock after 1+4+32 further cycles.
REQ-034 reset_n_in pulsed low during SETTLE -> all outputs 0 asynchronously; enable_in=0 for 1 cycle while locked -> sync_done=0 next cycle, slip_count and align_err unchanged.
